// File: rtl/scan_index_gen_if.sv
// Scan index generator bus: control inputs from the requester, index/status back.
// Optional macro SCAN_INDEX_GEN_SKIP_EN adds the skip_mask signal.
interface scan_index_gen_if;
   logic        start;
   logic        stop;
   logic        cont;
   logic [7:0]  dwell;
`ifdef SCAN_INDEX_GEN_SKIP_EN
   logic [15:0] skip_mask;
`endif
   logic [3:0]  idx;
   logic        idx_vld;
   logic        busy;
   logic        done;
   logic        abort;
   logic [7:0]  pass_cnt;

   modport master (
`ifdef SCAN_INDEX_GEN_SKIP_EN
      output skip_mask,
`endif
      output start, stop, cont, dwell,
      input  idx, idx_vld, busy, done, abort, pass_cnt
   );

   modport slave (
`ifdef SCAN_INDEX_GEN_SKIP_EN
      input  skip_mask,
`endif
      input  start, stop, cont, dwell,
      output idx, idx_vld, busy, done, abort, pass_cnt
   );
endinterface

// File: rtl/scan_index_gen.sv
// Scan index generator: steps a 4-bit index 0..15, holding each for dwell+1 cycles,
// with single-shot or continuous operation and stop/abort.
// Optional macro SCAN_INDEX_GEN_SKIP_EN: skip_mask removes indices from the sequence.
module scan_index_gen (
   input logic             clk,
   input logic             rst,
   scan_index_gen_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StDwell, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  dwell_q, dwell_d;
   logic [7:0]  pass_cnt_q, pass_cnt_d;
   logic [15:0] mask_q, mask_d;
   logic        cont_q, cont_d;
   logic        idx_vld_q, idx_vld_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        abort_q, abort_d;

   logic [15:0] mask_in;
   logic [4:0]  first_sel;  // {found, index} for the scan being started
   logic [4:0]  wrap_sel;   // {found, index} for a continuous-mode wrap
   logic [4:0]  next_sel;   // {found, index} for the next step above idx_q

`ifdef SCAN_INDEX_GEN_SKIP_EN
   assign mask_in = bus.skip_mask;
`else
   assign mask_in = 16'h0000;
`endif

   // Lowest unmasked index >= floor; floor is 5 bits so 16 means "none above 15".
   function automatic logic [4:0] lowest_from(input logic [15:0] mask, input logic [4:0] floor);
      logic [4:0] res;
      res = 5'd0;
      for (int i = 15; i >= 0; i--) begin
         if (!mask[i] && (5'(i) >= floor)) res = {1'b1, 4'(i)};
      end
      return res;
   endfunction

   assign first_sel = lowest_from(mask_in, 5'd0);
   assign wrap_sel  = lowest_from(mask_q, 5'd0);
   assign next_sel  = lowest_from(mask_q, {1'b0, idx_q} + 5'd1);

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      dwell_d    = dwell_q;
      pass_cnt_d = pass_cnt_q;
      mask_d     = mask_q;
      cont_d     = cont_q;
      idx_vld_d  = idx_vld_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      abort_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            idx_d     = 4'd0;
            idx_vld_d = 1'b0;
            busy_d    = 1'b0;
            // start together with stop is ignored
            if (bus.start && !bus.stop) begin
               dwell_d    = bus.dwell;
               cont_d     = bus.cont;
               mask_d     = mask_in;
               cnt_d      = bus.dwell;
               pass_cnt_d = 8'd0;
               busy_d     = 1'b1;
               if (first_sel[4]) begin
                  state_d   = StDwell;
                  idx_d     = first_sel[3:0];
                  idx_vld_d = 1'b1;
               end else begin
                  // Every index masked: nothing to present, finish at once.
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
         end

         StDwell: begin
            if (bus.stop) begin
               state_d   = StIdle;
               idx_d     = 4'd0;
               idx_vld_d = 1'b0;
               busy_d    = 1'b0;
               abort_d   = 1'b1;
            end else if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (next_sel[4]) begin
               idx_d = next_sel[3:0];
               cnt_d = dwell_q;
            end else if (cont_q && wrap_sel[4]) begin
               idx_d      = wrap_sel[3:0];
               cnt_d      = dwell_q;
               pass_cnt_d = pass_cnt_q + 8'd1;
            end else begin
               state_d   = StDone;
               idx_d     = 4'd0;
               idx_vld_d = 1'b0;
               done_d    = 1'b1;
            end
         end

         StDone: begin
            state_d   = StIdle;
            idx_d     = 4'd0;
            idx_vld_d = 1'b0;
            busy_d    = 1'b0;
            abort_d   = bus.stop;
         end

         default: begin
            state_d   = StIdle;
            idx_d     = 4'd0;
            idx_vld_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= 4'd0;
         cnt_q      <= 8'd0;
         dwell_q    <= 8'd0;
         pass_cnt_q <= 8'd0;
         mask_q     <= 16'h0000;
         cont_q     <= 1'b0;
         idx_vld_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         dwell_q    <= dwell_d;
         pass_cnt_q <= pass_cnt_d;
         mask_q     <= mask_d;
         cont_q     <= cont_d;
         idx_vld_q  <= idx_vld_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
      end
   end

   assign bus.idx      = idx_q;
   assign bus.idx_vld  = idx_vld_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.abort    = abort_q;
   assign bus.pass_cnt = pass_cnt_q;
endmodule
